// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_pkg;

  localparam logic [31:0] PC_INIT    = 32'h8002_0000;
  localparam int          WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of PC-tagged instructions with flush.
// The caller never pushes into a full FIFO unless it pops in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_pop;

  // Pop on an empty FIFO is ignored so the caller can wire ready straight in.
  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch: credit-limited sequential fetch, in-order response
// collection, PC-tagged buffering and redirect flush with stale-response drop.
module fetch_queue #(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] PC_INIT = fetch_pkg::PC_INIT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  import fetch_pkg::*;

  localparam int          CW   = $clog2(DEPTH + 1);
  localparam logic [31:0] STEP = 32'(WORD_BYTES);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // Requests are not sticky; memory samples address only on that edge.
  // Responses carry no ready and arrive in request order.

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic [CW-1:0] inflight_less_rsp;
  logic [31:0]   redirect_word;
  logic          req_fire;
  logic          rsp_keep;
  logic          rsp_drop;
  logic          unused_pc_bits;
  fetch_entry_t  push_data;
  fetch_entry_t  head;

  assign unused_pc_bits = ^redirect_pc[1:0];
  assign redirect_word  = {redirect_pc[31:2], 2'b00};

  // Credit counts both buffered and outstanding words; a pop frees credit
  // only from the next cycle on.
  assign occupancy     = {1'b0, count} + {1'b0, inflight};
  assign mem_req_valid = !reset && !redirect && (occupancy < (CW + 1)'(DEPTH));
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign rsp_keep = mem_rsp_valid && !redirect && (drop == '0);
  assign rsp_drop = mem_rsp_valid && !redirect && (drop != '0);
  assign inflight_less_rsp = inflight - CW'(mem_rsp_valid);

  assign push_data.pc    = rsp_pc;
  assign push_data.instr = mem_rsp_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= PC_INIT;
      rsp_pc   <= PC_INIT;
      inflight <= '0;
      drop     <= '0;
    end else if (redirect) begin
      // Everything still outstanding belongs to the old stream.
      fetch_pc <= redirect_word;
      rsp_pc   <= redirect_word;
      inflight <= inflight_less_rsp;
      drop     <= inflight_less_rsp;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + STEP;
      end
      if (rsp_keep) begin
        rsp_pc <= rsp_pc + STEP;
      end
      if (rsp_drop) begin
        drop <= drop - CW'(1);
      end
      inflight <= inflight + CW'(req_fire) - CW'(mem_rsp_valid);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rsp_keep),
    .push_data (push_data),
    .pop       (instr_ready && !redirect),
    .flush     (redirect),
    .count     (count),
    .head      (head)
  );

  assign instr_valid = (count != '0);
  assign instr_out   = head.instr;
  assign instr_pc    = head.pc;

endmodule
